// File: rtl/hall_slicer_pkg.sv
// Shared types and helpers for the hall-sensor revolution slicer.
package hall_slicer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAL,
    RUN
  } hall_state_t;

  // Number of bits to shift the period right by to get one slice length.
  function automatic int unsigned slice_shift(int unsigned nb_slices);
    return $clog2(nb_slices);
  endfunction

endpackage

// File: rtl/hall_slicer_slice_timer.sv
// Splits one revolution into equal slices: pulses new_slice at each slice start and tracks
// the current slice index. A restart always wins over a regular slice boundary, and the index
// parks on the last slice until the next restart instead of wrapping.
module slice_timer
  import hall_slicer_pkg::*;
#(
  parameter int unsigned NB_SLICES = 256,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned IDX_W     = slice_shift(NB_SLICES)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic             restart,
  input  logic [CNT_W-1:0] slice_len,
  output logic             new_slice,
  output logic [IDX_W-1:0] slice_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_SLICES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [IDX_W-1:0] slice_idx_q, slice_idx_d;
  logic             new_slice_q, new_slice_d;

  // Next-state: disable clears, restart wins, otherwise advance on slice boundaries.
  always_comb begin
    slice_cnt_d = slice_cnt_q;
    slice_idx_d = slice_idx_q;
    new_slice_d = 1'b0;
    if (!enable) begin
      slice_cnt_d = '0;
      slice_idx_d = '0;
    end else if (restart) begin
      slice_cnt_d = '0;
      slice_idx_d = '0;
      new_slice_d = 1'b1;
    end else if ((slice_idx_q != LAST_IDX) && (slice_cnt_q == slice_len - CNT_ONE)) begin
      slice_cnt_d = '0;
      slice_idx_d = slice_idx_q + 1'b1;
      new_slice_d = 1'b1;
    end else if (slice_cnt_q != '1) begin
      // Keeps counting while parked on the last slice; saturates so it never re-arms.
      slice_cnt_d = slice_cnt_q + CNT_ONE;
    end
  end

  // Slice state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slice_cnt_q <= '0;
      slice_idx_q <= '0;
      new_slice_q <= 1'b0;
    end else begin
      slice_cnt_q <= slice_cnt_d;
      slice_idx_q <= slice_idx_d;
      new_slice_q <= new_slice_d;
    end
  end

  assign new_slice = new_slice_q;
  assign slice_idx = slice_idx_q;

endmodule

// File: rtl/hall_slicer.sv
// Turns magnet passes on the hall sensor into a revolution reference, measures the period
// and drives a slice timer that divides each revolution into NB_SLICES angular slices.
module hall_slicer
  import hall_slicer_pkg::*;
#(
  parameter int unsigned NB_SLICES = 256,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MIN_GAP   = 1024,
  parameter int unsigned TIMEOUT   = 2 ** 26
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         hall_in,
  output logic                         new_slice,
  output logic [$clog2(NB_SLICES)-1:0] slice_idx,
  output logic                         locked,
  output logic [CNT_W-1:0]             period
);

  localparam int unsigned      SLICE_SHIFT = slice_shift(NB_SLICES);
  localparam logic [CNT_W-1:0] MIN_GAP_C   = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  hall_state_t      state_q;
  logic             hall_prev_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic             locked_q;

  logic             raw_edge;
  logic             accepted;
  logic             timeout;
  logic             run_next;
  logic             restart;
  logic [CNT_W-1:0] elapsed;
  logic [CNT_W-1:0] slice_shifted;
  logic [CNT_W-1:0] slice_len;

  // Edge qualification, lockout and timeout decisions for this cycle.
  always_comb begin
    raw_edge = hall_prev_q & ~hall_in;
    // gap_cnt counts cycles strictly after an edge, so the interval including this cycle is +1.
    elapsed  = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + CNT_ONE;
    accepted = raw_edge & ((elapsed >= MIN_GAP_C) | (state_q == IDLE));
    timeout  = (state_q != IDLE) & (elapsed >= TIMEOUT_C);
    restart  = accepted & (state_q != IDLE);
    run_next = accepted ? (state_q != IDLE) : ((state_q == RUN) & ~timeout);
  end

  // Slice length from the latest period, never zero.
  always_comb begin
    slice_shifted = period_q >> SLICE_SHIFT;
    slice_len     = (slice_shifted == '0) ? CNT_ONE : slice_shifted;
  end

  // Input history and saturating gap counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hall_prev_q <= 1'b1;
      gap_cnt_q   <= '0;
    end else begin
      hall_prev_q <= hall_in;
      if (accepted) begin
        gap_cnt_q <= '0;
      end else if (gap_cnt_q != '1) begin
        gap_cnt_q <= gap_cnt_q + CNT_ONE;
      end
    end
  end

  // Reference FSM with registered period and lock flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      period_q <= '0;
      locked_q <= 1'b0;
    end else if (accepted) begin
      unique case (state_q)
        IDLE: begin
          state_q  <= CAL;
          locked_q <= 1'b0;
        end
        CAL, RUN: begin
          state_q  <= RUN;
          period_q <= elapsed;
          locked_q <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          locked_q <= 1'b0;
        end
      endcase
    end else if (timeout) begin
      // Period is kept so the last measurement stays observable after lock loss.
      state_q  <= IDLE;
      locked_q <= 1'b0;
    end
  end

  slice_timer #(
    .NB_SLICES(NB_SLICES),
    .CNT_W    (CNT_W),
    .IDX_W    (SLICE_SHIFT)
  ) u_slice_timer (
    .clk      (clk),
    .nrst     (nrst),
    .enable   (run_next),
    .restart  (restart),
    .slice_len(slice_len),
    .new_slice(new_slice),
    .slice_idx(slice_idx)
  );

  assign locked = locked_q;
  assign period = period_q;

endmodule

// File: tb/tb_hall_slicer.sv
// Self-checking bench for hall_slicer: an arithmetic revolution model checked every cycle,
// plus literal expectations at the interesting moments of each scenario.
module tb_hall_slicer;

  localparam int NB     = 4;
  localparam int CW     = 16;
  localparam int MINGAP = 8;
  localparam int TMO    = 1000;
  localparam int SAT    = 65535;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          hall_in = 1'b1;
  logic          new_slice;
  logic [1:0]    slice_idx;
  logic          locked;
  logic [CW-1:0] period;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: mode 0 idle, 1 calibrating, 2 running.
  int cyc      = 0;
  int m_mode   = 0;
  bit m_prev   = 1'b1;
  int m_last   = 0;
  int m_period = 0;
  int m_k      = 0;

  hall_slicer #(
    .NB_SLICES(NB),
    .CNT_W    (CW),
    .MIN_GAP  (MINGAP),
    .TIMEOUT  (TMO)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .hall_in  (hall_in),
    .new_slice(new_slice),
    .slice_idx(slice_idx),
    .locked   (locked),
    .period   (period)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: tracks edges as absolute cycle numbers, slices by division.
  initial begin
    int  elapsed;
    bit  acc;
    forever begin
      @(posedge clk or negedge nrst);
      if (!nrst) begin
        cyc = 0; m_mode = 0; m_prev = 1'b1; m_last = 0; m_period = 0; m_k = 0;
      end else begin
        cyc++;
        elapsed = cyc - m_last;
        if (elapsed > SAT) elapsed = SAT;
        acc = m_prev && !hall_in && (m_mode == 0 || elapsed >= MINGAP);
        if (acc) begin
          if (m_mode == 0) begin
            m_mode = 1;
          end else begin
            m_mode   = 2;
            m_period = elapsed;
            m_k      = 0;
          end
          m_last = cyc;
        end else if (m_mode != 0 && elapsed >= TMO) begin
          m_mode = 0;
        end else if (m_mode == 2) begin
          m_k++;
        end
        m_prev = hall_in;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    int len, q, e_idx, e_ns, e_lock;
    forever begin
      @(negedge clk);
      if (nrst) begin
        e_lock = (m_mode == 2) ? 1 : 0;
        e_idx  = 0;
        e_ns   = 0;
        if (e_lock == 1) begin
          len = m_period / NB;
          if (len == 0) len = 1;
          q     = m_k / len;
          e_idx = (q > NB - 1) ? NB - 1 : q;
          e_ns  = ((m_k % len) == 0 && q <= NB - 1) ? 1 : 0;
        end
        check("model_locked", int'(locked), e_lock);
        check("model_period", int'(period), m_period);
        check("model_slice_idx", int'(slice_idx), e_idx);
        check("model_new_slice", int'(new_slice), e_ns);
      end
    end
  end

  // Advance to just after the posedge numbered c.
  task automatic at_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < c) check("cycle_reach", cyc, c);
  endtask

  // Make the DUT see a falling edge at posedge c (hall low for one sample).
  task automatic fall_at(input int c);
    at_cyc(c - 1);
    hall_in = 1'b0;
    @(posedge clk);
    #1;
    hall_in = 1'b1;
  endtask

  task automatic expect_out(input string tag, input int ns, input int idx, input int lk,
                            input int per);
    check({tag, "_new_slice"}, int'(new_slice), ns);
    check({tag, "_slice_idx"}, int'(slice_idx), idx);
    check({tag, "_locked"}, int'(locked), lk);
    check({tag, "_period"}, int'(period), per);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    #1;
    nrst = 1'b1;

    // Steady 400-cycle revolutions.
    fall_at(10);
    at_cyc(300);
    expect_out("cal", 0, 0, 0, 0);
    fall_at(410);
    expect_out("lock", 1, 0, 1, 400);
    at_cyc(510);
    expect_out("slice1", 1, 1, 1, 400);
    at_cyc(710);
    expect_out("slice3", 1, 3, 1, 400);
    at_cyc(711);
    expect_out("slice3_hold", 0, 3, 1, 400);
    fall_at(810);
    fall_at(1210);
    expect_out("rev3", 1, 0, 1, 400);

    // Glitch 5 cycles after an accepted edge, then an edge at gap 8.
    fall_at(1215);
    expect_out("glitch", 0, 0, 1, 400);
    fall_at(1218);
    expect_out("gap8", 1, 0, 1, 8);
    fall_at(1618);
    fall_at(2018);

    // Deceleration: next edge 600 cycles later.
    at_cyc(2318);
    expect_out("decel_last", 1, 3, 1, 400);
    at_cyc(2500);
    expect_out("decel_hold", 0, 3, 1, 400);
    fall_at(2618);
    expect_out("decel_edge", 1, 0, 1, 600);
    at_cyc(2768);
    expect_out("decel_len150", 1, 1, 1, 600);

    // Acceleration with the edge on the slice-2 boundary.
    fall_at(3218);
    fall_at(3618);
    at_cyc(3720);
    expect_out("accel_pre", 0, 1, 1, 400);
    fall_at(3818);
    expect_out("collide", 1, 0, 1, 200);
    at_cyc(3819);
    expect_out("collide_after", 0, 0, 1, 200);

    // Timeout after edges stop.
    fall_at(4218);
    at_cyc(5217);
    expect_out("pre_timeout", 0, 3, 1, 400);
    at_cyc(5218);
    expect_out("timeout", 0, 0, 0, 400);
    fall_at(5500);
    expect_out("relock_cal", 0, 0, 0, 400);
    fall_at(5900);
    expect_out("relock_run", 1, 0, 1, 400);

    // Asynchronous reset between pulses.
    at_cyc(5950);
    #2;
    nrst = 1'b0;
    #1;
    expect_out("async_rst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    nrst = 1'b1;
    fall_at(20);
    expect_out("post_rst_cal", 0, 0, 0, 0);
    fall_at(420);
    expect_out("post_rst_run", 1, 0, 1, 400);
    at_cyc(430);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hall_slicer.md
Name: hall_slicer

Overview:
- Consumes the majority-voted, synchronized hall-effect sensor level and turns each detected magnet pass into a revolution reference.
- Measures the revolution period in clk cycles and divides it into NB_SLICES equal angular slices.
- Emits a one-cycle tick at the start of each slice, plus the current slice index. The column/framebuffer readout stage uses these to pick which slice to display.

Parameters:
- NB_SLICES, 256, slices per revolution; power of two, ≥2.
- CNT_W, 32, width of period/cycle counters.
- MIN_GAP, 1024, minimum cycles between accepted edges (re-trigger lockout).
- TIMEOUT, 2**26, cycles without an accepted edge before lock is dropped; must be < 2**CNT_W − 1.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset.
- hall_in  in  1  synchronized hall level; magnet present = 0.
- new_slice  out  1  one-cycle pulse at start of each slice.
- slice_idx  out  $clog2(NB_SLICES)  index of current slice.
- locked  out  1  a valid period is known and slices are being generated.
- period  out  CNT_W  last measured revolution period, in cycles.

Behaviour:
- Reset: nrst is asynchronous, active-low; clock is clk.
  - During reset: new_slice=0, slice_idx=0, locked=0, period=0.
  - All counters = 0, state = IDLE, hall_prev = 1.
- Edge detect: raw edge = hall_prev & ~hall_in (falling edge). hall_prev is registered every cycle.
- Accepted edge: raw edge AND (gap_cnt ≥ MIN_GAP OR state == IDLE).
  - Raw edges inside the lockout window are ignored entirely: no counter change, no output change.
- gap_cnt:
  - Increments every cycle and saturates at 2**CNT_W−1.
  - Cleared to 0 on an accepted edge.
- States:
  - IDLE: no reference yet.
    - Accepted edge → CAL, with gap_cnt=0.
  - CAL: first revolution being measured; locked=0, no new_slice pulses.
    - Accepted edge → RUN, with period ← gap_cnt. Latency 1 cycle: period, locked=1 and the first new_slice appear in the cycle after the edge.
    - slice_idx ← 0.
  - RUN:
    - Accepted edge: period ← gap_cnt, slice_idx ← 0, slice_cnt ← 0, new_slice=1 (next cycle).
  - Any state with gap_cnt reaching TIMEOUT → IDLE.
    - locked=0, slice_idx=0, new_slice=0.
    - period keeps its last value.
- Slice length: slice_len = period >> log2(NB_SLICES), with floor rounding. If the result is 0, use 1.
- Slice timing in RUN:
  - slice_cnt increments each cycle.
  - When slice_cnt == slice_len−1 and slice_idx < NB_SLICES−1: slice_cnt ← 0, slice_idx ← slice_idx+1, new_slice pulses.
  - slice_idx == NB_SLICES−1 (rotor slowing): hold the index, emit no further pulses, keep counting until the next accepted edge. No wrap to 0 without an edge.
- Simultaneous accepted edge and slice boundary: the edge wins.
  - Exactly one new_slice pulse, with slice_idx=0.
  - No pulse for the would-be next slice.
- Rotor faster than estimate (edge arrives before slice NB_SLICES−1): the remaining slices are skipped; the index restarts at 0.
- Lost lock: new_slice is never asserted while locked=0.

Decomposition:
- Package hall_slicer_pkg holds:
  - typedef enum logic [1:0] {IDLE, CAL, RUN} hall_state_t.
  - localparam function for SLICE_SHIFT = $clog2(NB_SLICES).
- One sub-module, slice_timer:
  - Inputs: clk, nrst, enable, restart, slice_len.
  - Outputs: new_slice, slice_idx.
  - Owns slice_cnt, the hold-at-last-slice rule, and the restart priority.
- The top level keeps the edge detect, gap_cnt, period register and FSM.

Test Plan (bench overrides: NB_SLICES=4, MIN_GAP=8, TIMEOUT=1000, CNT_W=16):
1. Reset then steady edges:
   - Stimulus: hall_in falling edges at t=10, 410, 810.
   - After the 2nd edge: period=400, locked=1.
   - new_slice pulses at edge+1, +101, +201, +301 with slice_idx 0,1,2,3.
   - Pattern repeats after the 3rd edge.
2. Glitch rejection:
   - Stimulus: extra falling edge 5 cycles after an accepted edge in RUN.
   - Ignored: period unchanged, slice sequence unaffected.
   - An edge at gap 8 is accepted.
3. Deceleration:
   - Stimulus: steady 400-cycle period, then next edge at 600.
   - slice_idx holds at 3 from cycle 301 to 600, with no pulses.
   - At the edge: idx=0, period=600, next slice_len=150.
4. Acceleration plus collision:
   - Stimulus: after period 400, next edge exactly at cycle 200, which coincides with the slice-2 boundary.
   - Single new_slice with idx=0; slice 2 is never shown; period=200.
5. Timeout:
   - Stimulus: edges stop in RUN.
   - 1000 cycles after the last edge: locked=0, idx=0, no pulses, period retains 400.
   - Next edge → CAL; locked only after the following edge.
6. Asynchronous reset mid-RUN:
   - Stimulus: drop nrst between slice pulses.
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release, the first edge yields locked=0 (CAL).
